// File: rtl/rv32_inst_encoder_if.sv
// Request/response bundle for the RV32 instruction encoder.
// The slave modport is the encoder's view; the master modport is the requester/consumer's view.
interface rv32_inst_encoder_if #(
  parameter int count_width_p = 16
) ();
  logic                     v_i;
  logic                     ready_o;
  logic [2:0]               cmd_i;
  logic [4:0]               rd_i;
  logic [4:0]               rs1_i;
  logic [4:0]               rs2_i;
  logic [2:0]               funct3_i;
  logic [6:0]               funct7_i;
  logic [31:0]              imm_i;
  logic                     v_o;
  logic [31:0]              instr_o;
  logic                     ready_i;
  logic                     error_o;
  logic [count_width_p-1:0] emitted_count_o;

  modport slave (
    input  v_i, cmd_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, ready_i,
    output ready_o, v_o, instr_o, error_o, emitted_count_o
  );

  modport master (
    output v_i, cmd_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, ready_i,
    input  ready_o, v_o, instr_o, error_o, emitted_count_o
  );
endinterface

// File: rtl/rv32_inst_encoder.sv
// Sequential RV32I/Zicsr encoder: field-level requests in, 32-bit instruction words out,
// with LI expanded to ADDI or LUI(+ADDI). One registered output word, full throughput.
module rv32_inst_encoder #(
  parameter int count_width_p = 16,
  parameter bit enable_li_p   = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rv32_inst_encoder_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic {
    S_IDLE,
    S_HOLD2
  } state_t;

  state_t                   r_state;
  logic                     r_v;
  logic [31:0]              r_instr;
  logic [31:0]              r_pend;
  logic                     r_error;
  logic [count_width_p-1:0] r_count;

  logic        w_accept;
  logic        w_out_hs;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic [19:0] w_upper;
  logic [31:0] w_word1;
  logic [31:0] w_word2;
  logic        w_two;
  logic        w_illegal;

  assign bus.ready_o         = (~r_v | bus.ready_i) & (r_state != S_HOLD2);
  assign bus.v_o             = r_v;
  assign bus.instr_o         = r_instr;
  assign bus.error_o         = r_error;
  assign bus.emitted_count_o = r_count;

  assign w_accept = bus.v_i & bus.ready_o;
  assign w_out_hs = r_v & bus.ready_i;

  // A value fits N signed bits when bits [31:N-1] are all copies of the sign.
  assign w_fit12 = (&bus.imm_i[31:11]) | ~(|bus.imm_i[31:11]);
  assign w_fit13 = (&bus.imm_i[31:12]) | ~(|bus.imm_i[31:12]);
  assign w_fit21 = (&bus.imm_i[31:20]) | ~(|bus.imm_i[31:20]);

  // Rounding up by imm[11] compensates for ADDI sign-extending the low 12 bits.
  assign w_upper = bus.imm_i[31:12] + {19'd0, bus.imm_i[11]};

  always_comb begin
    w_word1   = '0;
    w_word2   = '0;
    w_two     = 1'b0;
    w_illegal = 1'b0;
    case (bus.cmd_i)
      3'd0: w_word1 = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, OPC_OP};
      3'd1: begin
        w_illegal = ~w_fit12;
        w_word1   = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OPC_OP_IMM};
      end
      3'd2: begin
        w_illegal = ~w_fit12;
        w_word1   = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OPC_LOAD};
      end
      3'd3: begin
        w_illegal = ~w_fit12;
        w_word1   = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.imm_i[4:0],
                     OPC_STORE};
      end
      3'd4: begin
        w_illegal = bus.imm_i[0] | ~w_fit13;
        w_word1   = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                     bus.imm_i[4:1], bus.imm_i[11], OPC_BRANCH};
      end
      3'd5: begin
        w_illegal = bus.imm_i[0] | ~w_fit21;
        w_word1   = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11], bus.imm_i[19:12],
                     bus.rd_i, OPC_JAL};
      end
      3'd6: begin
        if (!enable_li_p) begin
          w_illegal = 1'b1;
        end else if (w_fit12) begin
          w_word1 = {bus.imm_i[11:0], 5'd0, 3'b000, bus.rd_i, OPC_OP_IMM};
        end else begin
          w_word1 = {w_upper, bus.rd_i, OPC_LUI};
          w_word2 = {bus.imm_i[11:0], bus.rd_i, 3'b000, bus.rd_i, OPC_OP_IMM};
          w_two   = |bus.imm_i[11:0];
        end
      end
      default: w_word1 = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OPC_CSR};
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_v     <= 1'b0;
      r_instr <= '0;
      r_pend  <= '0;
      r_error <= 1'b0;
      r_count <= '0;
    end else begin
      r_error <= w_accept & w_illegal;
      if (w_out_hs) begin
        r_count <= r_count + count_width_p'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_illegal) begin
            r_v     <= 1'b1;
            r_instr <= w_word1;
            if (w_two) begin
              r_pend  <= w_word2;
              r_state <= S_HOLD2;
            end
          end else if (w_out_hs) begin
            r_v <= 1'b0;
          end
        end
        S_HOLD2: begin
          // The buffered ADDI replaces the LUI as it leaves; v_o stays high.
          if (w_out_hs) begin
            r_instr <= r_pend;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Scoreboard bench for rv32_inst_encoder: stimulus pushes expected words/errors,
// a monitor pops and compares on every output handshake and error pulse.
module tb_rv32_inst_encoder;

  localparam logic [2:0] C_OP     = 3'd0;
  localparam logic [2:0] C_OP_IMM = 3'd1;
  localparam logic [2:0] C_LOAD   = 3'd2;
  localparam logic [2:0] C_STORE  = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4;
  localparam logic [2:0] C_JAL    = 3'd5;
  localparam logic [2:0] C_LI     = 3'd6;
  localparam logic [2:0] C_CSR    = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_inst_encoder_if #(.count_width_p(3)) bus ();

  rv32_inst_encoder #(
    .count_width_p(3),
    .enable_li_p  (1'b1)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  int err_pending = 0;
  int cyc = 0;
  int start;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back(w);
    exp_cnt++;
  endtask

  task automatic expect_err();
    err_pending++;
  endtask

  // Holds the request until accepted; returns on the falling edge after the accepting edge.
  task automatic send(input logic [2:0] cmd, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    bit acc;
    acc          = 1'b0;
    bus.cmd_i    = cmd;
    bus.rd_i     = rd;
    bus.rs1_i    = rs1;
    bus.rs2_i    = rs2;
    bus.funct3_i = f3;
    bus.funct7_i = f7;
    bus.imm_i    = imm;
    bus.v_i      = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #1;
      acc = bus.ready_o;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got not-accepted want accepted (cmd %0d imm %h)", cmd, imm);
    end
    bus.v_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #3;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.v_o && bus.ready_i) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL word: got %h want none", bus.instr_o);
          end else begin
            w = exp_q.pop_front();
            if (bus.instr_o !== w) begin
              bad++;
              $display("FAIL word: got %h want %h", bus.instr_o, w);
            end else begin
              $display("ok   word: %h", bus.instr_o);
            end
          end
        end
        if (bus.error_o) begin
          total++;
          if (err_pending == 0) begin
            bad++;
            $display("FAIL error: got pulse want none");
          end else begin
            err_pending--;
            $display("ok   error pulse");
          end
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.v_i      = 1'b0;
    bus.ready_i  = 1'b0;
    bus.cmd_i    = '0;
    bus.rd_i     = '0;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;
    bus.funct3_i = '0;
    bus.funct7_i = '0;
    bus.imm_i    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_v_o", 32'(bus.v_o), 32'd0);
    check("rst_instr", bus.instr_o, 32'd0);
    check("rst_error", 32'(bus.error_o), 32'd0);
    check("rst_count", 32'(bus.emitted_count_o), 32'd0);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // LI two-word expansion, ready held high
    bus.ready_i = 1'b1;
    expect_word(32'h123452B7);
    expect_word(32'h67828293);
    send(C_LI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    #1;
    check("li_hold2_ready", 32'(bus.ready_o), 32'd0);
    check("li_lui_out", bus.instr_o, 32'h123452B7);
    drain();
    check("cnt_after_li", 32'(bus.emitted_count_o), 32'(exp_cnt & 7));

    expect_word(32'h000010B7);
    expect_word(32'h80008093);
    send(C_LI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    expect_word(32'hFFB00193);
    send(C_LI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB);
    expect_word(32'h00007237);
    send(C_LI, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00007000);

    // Branch legal then misaligned
    expect_word(32'h00208463);
    send(C_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    expect_err();
    send(C_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    #1;
    check("br_bad_error", 32'(bus.error_o), 32'd1);
    check("br_bad_v_o", 32'(bus.v_o), 32'd0);
    @(negedge clk);
    #1;
    check("br_bad_pulse_end", 32'(bus.error_o), 32'd0);

    expect_word(32'h002081B3);
    send(C_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    expect_word(32'h402081B3);
    send(C_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    expect_word(32'h0020A423);
    send(C_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    expect_word(32'hFFC0A283);
    send(C_LOAD, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC);
    expect_word(32'h300110F3);
    send(C_CSR, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'h00000300);
    expect_word(32'hFE000EE3);
    send(C_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    expect_word(32'h001000EF);
    send(C_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    expect_err();
    send(C_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    expect_err();
    send(C_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
    expect_err();
    send(C_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    expect_err();
    send(C_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
    drain();
    check("cnt_after_mix", 32'(bus.emitted_count_o), 32'(exp_cnt & 7));

    // Backpressure during HOLD2, then the queued request follows without a gap
    bus.ready_i = 1'b0;
    expect_word(32'h123452B7);
    expect_word(32'h67828293);
    send(C_LI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_hold_instr%0d", i), bus.instr_o, 32'h123452B7);
      check($sformatf("bp_hold_ready%0d", i), 32'(bus.ready_o), 32'd0);
      @(negedge clk);
    end
    bus.ready_i = 1'b1;
    start = cyc;
    expect_word(32'h00100313);
    send(C_OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    #1;
    check("bp_no_gap_cycles", 32'(cyc - start), 32'd2);
    check("bp_next_word", bus.instr_o, 32'h00100313);
    drain();

    // Back-to-back OP_IMM stream, counter wraps at 3 bits
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      expect_word((32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
      send(C_OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
    end
    check("stream_cycles", 32'(cyc - start), 32'd8);
    drain();
    check("cnt_after_stream", 32'(bus.emitted_count_o), 32'(exp_cnt & 7));

    // Asynchronous reset while in HOLD2
    bus.ready_i = 1'b0;
    expect_word(32'h123452B7);
    expect_word(32'h67828293);
    send(C_LI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    #3;
    rst = 1'b1;
    #1;
    check("arst_v_o", 32'(bus.v_o), 32'd0);
    check("arst_count", 32'(bus.emitted_count_o), 32'd0);
    check("arst_ready", 32'(bus.ready_o), 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("arst_no_addi", 32'(bus.v_o), 32'd0);
    check("arst_count_after", 32'(bus.emitted_count_o), 32'd0);

    check("errors_all_seen", 32'(err_pending), 32'd0);
    check("words_all_seen", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
